// File: rtl/axi_pkg.sv
// Shared AXI constants, client IDs and bridge state encoding for the memory bridge.
package axi_pkg;
    localparam logic [2:0] AXI_SIZE_8B    = 3'd3;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    localparam logic [3:0] IFU_ID_DEF = 4'd0;
    localparam logic [3:0] LSU_ID_DEF = 4'd1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AR,
        ST_R,
        ST_AWW,
        ST_B
    } bridge_state_e;

    // Clamp a requested beats-1 value so a burst never exceeds max_beats.
    function automatic logic [7:0] sat_len(input logic [7:0] len, input logic [7:0] max_beats);
        if (len >= max_beats) return max_beats - 8'd1;
        return len;
    endfunction
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; index 0 = IFU, index 1 = LSU. IFU wins the first tie.
module rr_arb2 (
    input  logic       aclk,
    input  logic       aresetn,
    input  logic [1:0] req,
    input  logic       accept,
    output logic [1:0] grant
);
    logic last_q;

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_q ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) last_q <= 1'b1;
        else if (accept) last_q <= grant[1];
    end
endmodule

// File: rtl/axi_mem_bridge.sv
// AXI4 master bridge serving IFU read bursts and LSU single-beat reads/writes, one transaction at a time.
//   state | meaning
//   IDLE  | arbitrate clients, accept one request
//   AR    | drive read address until arready
//   R     | forward read beats to the owning client
//   AWW   | drive write address and data channels independently
//   B     | wait for write response, report to LSU
module axi_mem_bridge
    import axi_pkg::*;
#(
    parameter int         IFU_MAX_LEN = 4,
    parameter logic [3:0] IFU_ID      = IFU_ID_DEF,
    parameter logic [3:0] LSU_ID      = LSU_ID_DEF
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        ifu_req_valid,
    output logic        ifu_req_ready,
    input  logic [31:0] ifu_req_addr,
    input  logic [7:0]  ifu_req_len,
    output logic        ifu_rsp_valid,
    output logic [63:0] ifu_rsp_data,
    output logic        ifu_rsp_last,
    output logic        ifu_rsp_err,
    input  logic        lsu_req_valid,
    output logic        lsu_req_ready,
    input  logic        lsu_req_wen,
    input  logic [31:0] lsu_req_addr,
    input  logic [63:0] lsu_req_wdata,
    input  logic [7:0]  lsu_req_wstrb,
    output logic        lsu_rsp_valid,
    output logic [63:0] lsu_rsp_data,
    output logic        lsu_rsp_err,
    output logic [31:0] araddr,
    output logic [3:0]  arid,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    output logic        arvalid,
    input  logic        arready,
    input  logic [3:0]  rid,
    input  logic [63:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    input  logic        rvalid,
    output logic        rready,
    output logic [31:0] awaddr,
    output logic [3:0]  awid,
    output logic [7:0]  awlen,
    output logic [2:0]  awsize,
    output logic [1:0]  awburst,
    output logic [1:0]  awlock,
    output logic [3:0]  awcache,
    output logic [2:0]  awprot,
    output logic        awvalid,
    input  logic        awready,
    output logic [3:0]  wid,
    output logic [63:0] wdata,
    output logic [7:0]  wstrb,
    output logic        wlast,
    output logic        wvalid,
    input  logic        wready,
    input  logic [3:0]  bid,
    input  logic [1:0]  bresp,
    input  logic        bvalid,
    output logic        bready
);
    bridge_state_e state_q, state_d;
    logic [31:0] addr_q;
    logic [7:0]  len_q, beat_q;
    logic [63:0] wdata_q;
    logic [7:0]  wstrb_q;
    logic        owner_q;
    logic        aw_done_q, w_done_q;
    logic [1:0]  grant;
    logic        aw_hs, w_hs, r_err, ifu_last;
    logic [3:0]  owner_id;
    logic        unused_bid;

    assign unused_bid = ^bid;

    rr_arb2 u_arb (
        .aclk    (aclk),
        .aresetn (aresetn),
        .req     ({lsu_req_valid, ifu_req_valid} & {2{state_q == ST_IDLE}}),
        .accept  (|grant),
        .grant   (grant)
    );

    assign ifu_req_ready = grant[0];
    assign lsu_req_ready = grant[1];

    assign owner_id = owner_q ? LSU_ID : IFU_ID;
    assign r_err    = (rresp != AXI_RESP_OKAY) || (rid != owner_id);
    assign ifu_last = rlast || (beat_q == len_q);
    assign aw_hs    = (state_q == ST_AWW) && !aw_done_q && awready;
    assign w_hs     = (state_q == ST_AWW) && !w_done_q && wready;

    // Address/data/ID outputs read zero outside the phase that uses them.
    assign araddr  = (state_q == ST_AR) ? addr_q : 32'd0;
    assign arid    = (state_q == ST_AR) ? owner_id : 4'd0;
    assign arlen   = (state_q == ST_AR) ? len_q : 8'd0;
    assign arsize  = AXI_SIZE_8B;
    assign arburst = AXI_BURST_INCR;
    assign arlock  = 2'b00;
    assign arcache = 4'b0000;
    assign arprot  = 3'b000;
    assign awaddr  = (state_q == ST_AWW) ? addr_q : 32'd0;
    assign awid    = (state_q == ST_AWW) ? LSU_ID : 4'd0;
    assign awlen   = 8'd0;
    assign awsize  = AXI_SIZE_8B;
    assign awburst = AXI_BURST_INCR;
    assign awlock  = 2'b00;
    assign awcache = 4'b0000;
    assign awprot  = 3'b000;
    assign wid     = (state_q == ST_AWW) ? LSU_ID : 4'd0;
    assign wdata   = (state_q == ST_AWW) ? wdata_q : 64'd0;
    assign wstrb   = (state_q == ST_AWW) ? wstrb_q : 8'd0;
    assign wlast   = 1'b1;

    always_comb begin
        state_d       = state_q;
        ifu_rsp_valid = 1'b0;
        ifu_rsp_data  = 64'd0;
        ifu_rsp_last  = 1'b0;
        ifu_rsp_err   = 1'b0;
        lsu_rsp_valid = 1'b0;
        lsu_rsp_data  = 64'd0;
        lsu_rsp_err   = 1'b0;
        arvalid       = 1'b0;
        rready        = 1'b0;
        awvalid       = 1'b0;
        wvalid        = 1'b0;
        bready        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant[0]) state_d = ST_AR;
                else if (grant[1]) state_d = lsu_req_wen ? ST_AWW : ST_AR;
            end
            ST_AR: begin
                arvalid = 1'b1;
                if (arready) state_d = ST_R;
            end
            ST_R: begin
                rready = 1'b1;
                if (rvalid) begin
                    if (owner_q) begin
                        lsu_rsp_valid = 1'b1;
                        lsu_rsp_data  = rdata;
                        lsu_rsp_err   = r_err;
                        state_d       = ST_IDLE;
                    end else begin
                        ifu_rsp_valid = 1'b1;
                        ifu_rsp_data  = rdata;
                        ifu_rsp_err   = r_err;
                        ifu_rsp_last  = ifu_last;
                        if (ifu_last) state_d = ST_IDLE;
                    end
                end
            end
            ST_AWW: begin
                awvalid = !aw_done_q;
                wvalid  = !w_done_q;
                if ((aw_done_q || aw_hs) && (w_done_q || w_hs)) state_d = ST_B;
            end
            ST_B: begin
                bready = 1'b1;
                if (bvalid) begin
                    lsu_rsp_valid = 1'b1;
                    lsu_rsp_err   = (bresp != AXI_RESP_OKAY);
                    state_d       = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q   <= ST_IDLE;
            addr_q    <= 32'd0;
            len_q     <= 8'd0;
            beat_q    <= 8'd0;
            wdata_q   <= 64'd0;
            wstrb_q   <= 8'd0;
            owner_q   <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (grant[0]) begin
                addr_q  <= ifu_req_addr;
                len_q   <= sat_len(ifu_req_len, 8'(IFU_MAX_LEN));
                owner_q <= 1'b0;
                beat_q  <= 8'd0;
            end else if (grant[1]) begin
                addr_q    <= lsu_req_addr;
                len_q     <= 8'd0;
                wdata_q   <= lsu_req_wdata;
                wstrb_q   <= lsu_req_wstrb;
                owner_q   <= 1'b1;
                beat_q    <= 8'd0;
                aw_done_q <= 1'b0;
                w_done_q  <= 1'b0;
            end
            if (state_q == ST_R && rvalid) beat_q <= beat_q + 8'd1;
            if (aw_hs) aw_done_q <= 1'b1;
            if (w_hs) w_done_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_axi_mem_bridge.sv
// Directed bench for axi_mem_bridge: the bench plays the AXI slave and both clients.
module tb_axi_mem_bridge;
    logic        aclk, aresetn;
    logic        ifu_req_valid, ifu_req_ready;
    logic [31:0] ifu_req_addr;
    logic [7:0]  ifu_req_len;
    logic        ifu_rsp_valid, ifu_rsp_last, ifu_rsp_err;
    logic [63:0] ifu_rsp_data;
    logic        lsu_req_valid, lsu_req_ready, lsu_req_wen;
    logic [31:0] lsu_req_addr;
    logic [63:0] lsu_req_wdata;
    logic [7:0]  lsu_req_wstrb;
    logic        lsu_rsp_valid, lsu_rsp_err;
    logic [63:0] lsu_rsp_data;
    logic [31:0] araddr, awaddr;
    logic [3:0]  arid, arcache, awid, awcache, wid, rid, bid;
    logic [7:0]  arlen, awlen, wstrb;
    logic [2:0]  arsize, arprot, awsize, awprot;
    logic [1:0]  arburst, arlock, awburst, awlock, rresp, bresp;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic [63:0] rdata, wdata;

    int n_assert = 0;
    int n_fail   = 0;

    axi_mem_bridge dut (
        .aclk(aclk), .aresetn(aresetn),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready),
        .ifu_req_addr(ifu_req_addr), .ifu_req_len(ifu_req_len),
        .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_data(ifu_rsp_data),
        .ifu_rsp_last(ifu_rsp_last), .ifu_rsp_err(ifu_rsp_err),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
        .lsu_req_wen(lsu_req_wen), .lsu_req_addr(lsu_req_addr),
        .lsu_req_wdata(lsu_req_wdata), .lsu_req_wstrb(lsu_req_wstrb),
        .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_data(lsu_rsp_data), .lsu_rsp_err(lsu_rsp_err),
        .araddr(araddr), .arid(arid), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awid(awid), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Inputs change at posedge+1, outputs are sampled at posedge+4.
    task automatic nxt();
        @(posedge aclk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic ifu_accept(input logic [31:0] addr, input logic [7:0] len);
        ifu_req_valid = 1'b1;
        ifu_req_addr  = addr;
        ifu_req_len   = len;
        settle();
        chk1("ifu_req_ready", ifu_req_ready, 1'b1);
        nxt();
        ifu_req_valid = 1'b0;
    endtask

    task automatic ar_phase(input logic [31:0] addr, input logic [7:0] len, input logic [3:0] id,
                            input int waits);
        for (int w = 0; w <= waits; w++) begin
            arready = (w == waits);
            settle();
            chk1("arvalid", arvalid, 1'b1);
            chk("araddr", 64'(araddr), 64'(addr));
            chk("arlen", 64'(arlen), 64'(len));
            chk("arid", 64'(arid), 64'(id));
            nxt();
        end
        arready = 1'b0;
    endtask

    task automatic r_beat_ifu(input logic [63:0] data, input logic [3:0] id, input logic last,
                              input logic exp_valid, input logic exp_last, input logic exp_err);
        rvalid = 1'b1;
        rdata  = data;
        rid    = id;
        rresp  = 2'b00;
        rlast  = last;
        settle();
        chk1("rready", rready, exp_valid);
        chk1("ifu_rsp_valid", ifu_rsp_valid, exp_valid);
        chk("ifu_rsp_data", ifu_rsp_data, exp_valid ? data : 64'd0);
        chk1("ifu_rsp_last", ifu_rsp_last, exp_last);
        chk1("ifu_rsp_err", ifu_rsp_err, exp_err);
        chk1("lsu_rsp_valid_quiet", lsu_rsp_valid, 1'b0);
        nxt();
        rvalid = 1'b0;
        rlast  = 1'b0;
    endtask

    initial begin
        aresetn = 1'b0;
        ifu_req_valid = 1'b0; ifu_req_addr = '0; ifu_req_len = '0;
        lsu_req_valid = 1'b0; lsu_req_wen = 1'b0; lsu_req_addr = '0;
        lsu_req_wdata = '0; lsu_req_wstrb = '0;
        arready = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b0; rvalid = 1'b0;
        awready = 1'b0; wready = 1'b0; bid = '0; bresp = '0; bvalid = 1'b0;
        repeat (3) nxt();
        aresetn = 1'b1;
        settle();
        chk1("rst_arvalid", arvalid, 1'b0);
        chk1("rst_awvalid", awvalid, 1'b0);
        chk1("rst_wvalid", wvalid, 1'b0);
        chk1("rst_rready", rready, 1'b0);
        chk1("rst_bready", bready, 1'b0);
        chk1("rst_ifu_req_ready", ifu_req_ready, 1'b0);
        chk1("rst_lsu_rsp_valid", lsu_rsp_valid, 1'b0);
        chk("rst_araddr", 64'(araddr), 64'd0);
        chk("rst_awid", 64'(awid), 64'd0);
        chk("arsize", 64'(arsize), 64'd3);
        chk("arburst", 64'(arburst), 64'd1);
        nxt();

        // 1: four-beat IFU burst, zero-wait slave
        ifu_accept(32'h8000_0000, 8'd3);
        ar_phase(32'h8000_0000, 8'd3, 4'd0, 0);
        for (int k = 0; k < 4; k++)
            r_beat_ifu(64'hA0 + 64'(k), 4'd0, (k == 3), 1'b1, (k == 3), 1'b0);
        settle();
        chk1("t1_idle_rready", rready, 1'b0);
        chk1("t1_idle_arvalid", arvalid, 1'b0);
        nxt();

        // 2: LSU write, awready late, wready immediate
        lsu_req_valid = 1'b1; lsu_req_wen = 1'b1; lsu_req_addr = 32'h8000_1008;
        lsu_req_wdata = 64'h1122_3344_5566_7788; lsu_req_wstrb = 8'h0F;
        settle();
        chk1("t2_lsu_req_ready", lsu_req_ready, 1'b1);
        chk1("t2_ifu_req_ready", ifu_req_ready, 1'b0);
        nxt();
        lsu_req_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            awready = (c == 3);
            wready  = (c == 0);
            settle();
            chk1("t2_awvalid", awvalid, 1'b1);
            chk1("t2_wvalid", wvalid, (c == 0));
            chk1("t2_lsu_req_ready_busy", lsu_req_ready, 1'b0);
            if (c == 0) begin
                chk("t2_awaddr", 64'(awaddr), 64'h8000_1008);
                chk("t2_wdata", wdata, 64'h1122_3344_5566_7788);
                chk("t2_wstrb", 64'(wstrb), 64'h0F);
                chk("t2_awid", 64'(awid), 64'd1);
                chk1("t2_wlast", wlast, 1'b1);
            end
            nxt();
        end
        awready = 1'b0; wready = 1'b0;
        settle();
        chk1("t2_b_awvalid", awvalid, 1'b0);
        chk1("t2_b_wvalid", wvalid, 1'b0);
        chk1("t2_b_bready", bready, 1'b1);
        chk1("t2_b_wait_rsp", lsu_rsp_valid, 1'b0);
        nxt();
        bvalid = 1'b1; bresp = 2'b00;
        settle();
        chk1("t2_lsu_rsp_valid", lsu_rsp_valid, 1'b1);
        chk1("t2_lsu_rsp_err", lsu_rsp_err, 1'b0);
        chk("t2_lsu_rsp_data", lsu_rsp_data, 64'd0);
        nxt();
        bvalid = 1'b0;
        settle();
        chk1("t2_rsp_pulse_end", lsu_rsp_valid, 1'b0);
        chk1("t2_bready_end", bready, 1'b0);
        nxt();

        // 3: simultaneous requests, round-robin IFU, LSU, IFU
        lsu_req_wen = 1'b0; lsu_req_addr = 32'h8000_3000; ifu_req_len = 8'd0;
        for (int r = 0; r < 3; r++) begin
            logic win_ifu;
            win_ifu = (r != 1);
            ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
            ifu_req_addr = 32'h8000_2000 + 32'(r * 8);
            settle();
            chk1("t3_ifu_grant", ifu_req_ready, win_ifu);
            chk1("t3_lsu_grant", lsu_req_ready, !win_ifu);
            nxt();
            if (win_ifu) ifu_req_valid = 1'b0; else lsu_req_valid = 1'b0;
            arready = 1'b1;
            settle();
            chk("t3_arid", 64'(arid), win_ifu ? 64'd0 : 64'd1);
            chk1("t3_loser_ifu_ready", ifu_req_ready, 1'b0);
            chk1("t3_loser_lsu_ready", lsu_req_ready, 1'b0);
            nxt();
            arready = 1'b0;
            rvalid = 1'b1; rlast = 1'b1; rresp = 2'b00; rdata = 64'h3300 + 64'(r);
            rid = win_ifu ? 4'd0 : 4'd1;
            settle();
            chk1("t3_ifu_rsp_valid", ifu_rsp_valid, win_ifu);
            chk1("t3_lsu_rsp_valid", lsu_rsp_valid, !win_ifu);
            chk1("t3_loser_ready_r", win_ifu ? lsu_req_ready : ifu_req_ready, 1'b0);
            nxt();
            rvalid = 1'b0; rlast = 1'b0;
        end
        ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;

        // 4: LSU read with SLVERR, then IFU beat with mismatched rid
        lsu_req_valid = 1'b1; lsu_req_wen = 1'b0; lsu_req_addr = 32'h8000_0010;
        settle();
        chk1("t4_lsu_req_ready", lsu_req_ready, 1'b1);
        nxt();
        lsu_req_valid = 1'b0;
        ar_phase(32'h8000_0010, 8'd0, 4'd1, 1);
        rvalid = 1'b1; rid = 4'd1; rresp = 2'd2; rlast = 1'b1; rdata = 64'hDEAD_BEEF_CAFE_F00D;
        settle();
        chk1("t4_lsu_rsp_valid", lsu_rsp_valid, 1'b1);
        chk1("t4_lsu_rsp_err", lsu_rsp_err, 1'b1);
        chk("t4_lsu_rsp_data", lsu_rsp_data, 64'hDEAD_BEEF_CAFE_F00D);
        chk1("t4_ifu_quiet", ifu_rsp_valid, 1'b0);
        nxt();
        rvalid = 1'b0; rlast = 1'b0; rresp = 2'd0;
        ifu_accept(32'h8000_0100, 8'd0);
        ar_phase(32'h8000_0100, 8'd0, 4'd0, 0);
        r_beat_ifu(64'h0BAD_0001, 4'd1, 1'b1, 1'b1, 1'b1, 1'b1);

        // 5: reset during beat 2 of a 4-beat burst
        ifu_accept(32'h8000_4000, 8'd3);
        ar_phase(32'h8000_4000, 8'd3, 4'd0, 0);
        r_beat_ifu(64'h5000, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        rvalid = 1'b1; rdata = 64'h5001; aresetn = 1'b0;
        nxt();
        rdata = 64'h5002;
        settle();
        chk1("t5_ifu_rsp_valid", ifu_rsp_valid, 1'b0);
        chk1("t5_rready", rready, 1'b0);
        chk1("t5_arvalid", arvalid, 1'b0);
        chk("t5_araddr", 64'(araddr), 64'd0);
        chk1("t5_ifu_req_ready", ifu_req_ready, 1'b0);
        chk1("t5_lsu_rsp_valid", lsu_rsp_valid, 1'b0);
        nxt();
        aresetn = 1'b1; rdata = 64'h5003; rlast = 1'b1;
        settle();
        chk1("t5_leftover_ifu_rsp", ifu_rsp_valid, 1'b0);
        chk1("t5_leftover_rready", rready, 1'b0);
        nxt();
        rvalid = 1'b0; rlast = 1'b0;
        ifu_accept(32'h8000_5000, 8'd1);
        ar_phase(32'h8000_5000, 8'd1, 4'd0, 0);
        r_beat_ifu(64'h5100, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        r_beat_ifu(64'h5101, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0);

        // 6: oversize IFU length saturates; last comes from the beat counter
        ifu_accept(32'h8000_6000, 8'd9);
        ar_phase(32'h8000_6000, 8'd3, 4'd0, 0);
        for (int k = 0; k < 4; k++)
            r_beat_ifu(64'h6000 + 64'(k), 4'd0, 1'b0, 1'b1, (k == 3), 1'b0);
        r_beat_ifu(64'h6004, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/axi_mem_bridge.md
Name: axi_mem_bridge

Overview:
AXI4 master bridge between the core's two memory clients (IFU fetch/refill, LSU load/store) and the simulated AXI4 SRAM slave.
- Arbitrates between the two clients and issues one AXI transaction at a time: read bursts for IFU, single-beat read/write for LSU.
- Returns read beats and write completion to the owning client.

Parameters:
IFU_MAX_LEN, 4, maximum IFU burst beats; ifu_req_len saturates to IFU_MAX_LEN-1
IFU_ID, 0, AXI ID for IFU transactions
LSU_ID, 1, AXI ID for LSU transactions

Ports:
aclk  in  1  clock
aresetn  in  1  synchronous active-low reset
ifu_req_valid  in  1  IFU read request
ifu_req_ready  out  1  IFU request accepted
ifu_req_addr  in  32  8-byte-aligned start address
ifu_req_len  in  8  beats-1
ifu_rsp_valid  out  1  IFU read beat valid (client must accept)
ifu_rsp_data  out  64  beat data
ifu_rsp_last  out  1  final beat
ifu_rsp_err  out  1  rresp!=0 or rid mismatch on this beat
lsu_req_valid  in  1  LSU request
lsu_req_ready  out  1  LSU request accepted
lsu_req_wen  in  1  1=write, 0=read
lsu_req_addr  in  32  8-byte-aligned address
lsu_req_wdata  in  64  write data
lsu_req_wstrb  in  8  byte strobes
lsu_rsp_valid  out  1  read data / write done, one-cycle pulse
lsu_rsp_data  out  64  read data; 0 for writes
lsu_rsp_err  out  1  rresp/bresp!=0
araddr, arid, arlen, arsize, arburst, arlock, arcache, arprot, arvalid  out  32,4,8,3,2,2,4,3,1  AXI AR
arready  in  1
rid, rdata, rresp, rlast, rvalid  in  4,64,2,1,1  AXI R
rready  out  1
awaddr, awid, awlen, awsize, awburst, awlock, awcache, awprot, awvalid  out  32,4,8,3,2,2,4,3,1  AXI AW
awready  in  1
wid, wdata, wstrb, wlast, wvalid  out  4,64,8,1,1  AXI W
wready  in  1
bid, bresp, bvalid  in  4,2,1  AXI B
bready  out  1

Behaviour:
- Reset: state IDLE; every valid/ready output 0; all address/data/ID outputs 0; last_grant=LSU, so IFU wins the first tie.
- Reset mid-transaction: abandon the transaction immediately. No rsp pulses after reset; slave-side leftovers are ignored.
- Constant fields: arsize=awsize=3, arburst=awburst=2'b01 INCR, lock/cache/prot=0, awlen=0, wlast=1, wid=awid=LSU_ID.
- FSM states: IDLE, AR, R, AWW, B.
- IDLE:
  - grant is combinational. Only one valid: grant it. Both valid: grant the client not equal to last_grant (round-robin).
  - Granted req_ready=1 in IDLE only; the other client's req_ready=0.
  - On handshake: register addr/len/wdata/wstrb/owner, update last_grant.
  - IFU or LSU read → AR. LSU write → AWW.
  - ifu len saturates to IFU_MAX_LEN-1; LSU reads use arlen=0.
- AR: arvalid=1 from registers. On arready → R. arvalid must not drop before arready.
- R:
  - rready=1. Each rvalid&rready beat is forwarded combinationally, same cycle, to the owner (rsp_valid, data, err).
  - err = rresp!=0 or rid!=owner ID.
  - ifu_rsp_last = rlast, or internal beat counter == len (whichever first). That beat ends the burst → IDLE.
  - LSU: the single beat ends → IDLE.
- AWW:
  - awvalid and wvalid both asserted on entry; each drops independently after its own handshake (aw_done/w_done flags).
  - Both done → B, including the same-cycle case.
  - A completed channel is never re-driven.
- B: bready=1. On bvalid: lsu_rsp_valid=1 same cycle, err=(bresp!=0), data=0 → IDLE.
- No new request is accepted until the current transaction returns to IDLE; req_ready is never 1 outside IDLE.
- Beat counter is 8 bits and cleared on every request accept.

Decomposition:
- Package axi_pkg: AXI burst/size/resp constants, IFU_ID/LSU_ID defaults, FSM state enum.
- Sub-module rr_arb2: 2-way round-robin arbiter (req[1:0], accept → grant, last_grant register). Everything else stays in one module.

Test Plan:
1. IFU req addr=0x80000000 len=3, slave zero wait → araddr=0x80000000 arlen=3 arid=0; 4 ifu_rsp_valid beats; last only on 4th; returns to IDLE the cycle after beat 4.
2. LSU write addr=0x80001008 wdata=0x1122334455667788 wstrb=0x0F; awready delayed 3 cycles, wready immediate → wvalid drops after 1 cycle, awvalid held 4 cycles; bresp=0 → one lsu_rsp_valid pulse, err=0.
3. IFU and LSU valid same cycle, repeated 3 times → grants IFU, LSU, IFU; losing req_ready stays 0 until granted.
4. LSU read 0x80000010, slave rresp=2 → lsu_rsp_valid=1, err=1, data=rdata; next IFU request still served.
5. aresetn low during beat 2 of 4-beat IFU burst → all outputs 0 next cycle; remaining slave beats produce no ifu_rsp_valid; post-reset IFU request issues a clean AR.
6. IFU len=9 with IFU_MAX_LEN=4 → arlen=3, exactly 4 beats returned.
